// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier with valid/ready handshakes.
//
// Retires BITS_PER_CYCLE multiplier bits per clock, so one product takes
// WIDTH/BITS_PER_CYCLE CALC cycles plus accept, FIX and output handshake.
// The accumulator is kept as a right-shifting register. Each iteration adds
// the partial product into the upper half and then shifts everything down by
// BITS_PER_CYCLE. This is the same sum as adding at an increasing bit offset,
// but it needs no barrel shifter.
//
// Optional feature, macro SEQ_MULT_SIGNED_EN:
//   defined   -> is_signed selects two's-complement operands. Magnitudes are
//                multiplied and the product is negated in FIX when the signs
//                differ.
//   undefined -> is_signed is ignored. All operands are unsigned and no
//                negation logic exists.
module seq_multiplier #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N      = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PW     = WIDTH + BITS_PER_CYCLE;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state_reg;
  logic [WIDTH-1:0]     a_reg;        // |A|, held for the whole operation
  logic [WIDTH-1:0]     b_reg;        // |B|, shifted right each iteration
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [2*WIDTH-1:0]   product_reg;
  logic                 out_valid_reg;
  logic                 busy_reg;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 sign_reg;     // product must be negated in FIX
`endif

  // Operand conditioning at accept time
  logic [WIDTH-1:0]     a_abs_next;
  logic [WIDTH-1:0]     b_abs_next;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 sign_next;
`endif

  // Datapath for one CALC iteration
  logic [PW-1:0]        pp_row [BITS_PER_CYCLE];
  logic [PW-1:0]        acc_sum_next;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     b_next;

  // Ready only in IDLE and never while reset is asserted
  assign in_ready  = (state_reg == ST_IDLE) && !rst;
  assign out_valid = out_valid_reg;
  assign product   = product_reg;
  assign busy      = busy_reg;

`ifdef SEQ_MULT_SIGNED_EN
  // Take magnitudes of negative operands and form the result sign
  always_comb begin
    a_abs_next = A;
    b_abs_next = B;
    sign_next  = 1'b0;
    if (is_signed) begin
      if (A[WIDTH-1]) a_abs_next = ~A + WIDTH'(1);
      if (B[WIDTH-1]) b_abs_next = ~B + WIDTH'(1);
      sign_next = A[WIDTH-1] ^ B[WIDTH-1];
    end
  end
`else
  // The mode input is left unconnected in the unsigned-only build
  logic unused_is_signed;
  assign unused_is_signed = is_signed;

  // Operands pass through unchanged in the unsigned-only build
  always_comb begin
    a_abs_next = A;
    b_abs_next = B;
  end
`endif

  // One row per multiplier bit of the current digit: |A| shifted by the bit
  // position, or zero when that bit of the digit is clear
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_row
    assign pp_row[gi] = b_reg[gi] ? ({{BITS_PER_CYCLE{1'b0}}, a_reg} << gi)
                                  : '0;
  end

  // Add the digit's partial product into the upper half of the accumulator,
  // then slide the accumulator and multiplier down by one digit. The upper
  // half plus |A| times a digit stays below 2^(WIDTH+BITS_PER_CYCLE), so
  // acc_sum_next cannot overflow.
  always_comb begin
    acc_sum_next = {{BITS_PER_CYCLE{1'b0}}, acc_reg[2*WIDTH-1:WIDTH]};
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      acc_sum_next = acc_sum_next + pp_row[j];
    end
    acc_next = (2*WIDTH)'({acc_sum_next, acc_reg[WIDTH-1:0]} >> BITS_PER_CYCLE);
    b_next   = b_reg >> BITS_PER_CYCLE;
  end

  // Control FSM with registered outputs: IDLE -> CALC x N -> FIX -> DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      product_reg   <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // in_ready is high here because rst is low in this branch
          if (in_valid) begin
            a_reg     <= a_abs_next;
            b_reg     <= b_abs_next;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
            sign_reg  <= sign_next;
`endif
            state_reg <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_reg <= acc_next;
          b_reg   <= b_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_LAST) begin
            state_reg <= ST_FIX;
          end
        end
        ST_FIX: begin
`ifdef SEQ_MULT_SIGNED_EN
          product_reg <= sign_reg ? (~acc_reg + (2*WIDTH)'(1)) : acc_reg;
`else
          product_reg <= acc_reg;
`endif
          out_valid_reg <= 1'b1;
          state_reg     <= ST_DONE;
        end
        ST_DONE: begin
          // Hold the result until the consumer takes it
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier (WIDTH=64, BITS_PER_CYCLE=4).
// Expected products are hand-computed constants. Signed-mode vectors pick
// their expectation according to SEQ_MULT_SIGNED_EN.
module tb_seq_multiplier;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   op_a;
  logic [63:0]   op_b;
  logic          op_signed;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  product;
  logic          busy;

  int n_checks;
  int n_errors;

  seq_multiplier #(.WIDTH(64), .BITS_PER_CYCLE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (op_a),
    .B         (op_b),
    .is_signed (op_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full operation: accept, wait for out_valid, check latency/result, handshake.
  // With early set, out_ready is high before out_valid rises.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic [127:0] exp, input logic early);
    int cycles;
    @(posedge clk); #1;
    check({tag, ".in_ready_idle"}, 128'(in_ready), 128'(1));
    op_a      = a;
    op_b      = b;
    op_signed = s;
    in_valid  = 1'b1;
    out_ready = early;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".busy_accept"}, 128'(busy), 128'(1));
    check({tag, ".in_ready_busy"}, 128'(in_ready), 128'(0));
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, ".latency"}, 128'(cycles), 128'(17));
    check({tag, ".product"}, product, exp);
    if (!early) begin
      check({tag, ".in_ready_done"}, 128'(in_ready), 128'(0));
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, 128'(out_valid), 128'(0));
    check({tag, ".busy_idle"}, 128'(busy), 128'(0));
    check({tag, ".in_ready_back"}, 128'(in_ready), 128'(1));
    $display("op %s: A=%h B=%h signed=%0d product=%h latency=%0d", tag, a, b, s, exp, cycles);
  endtask

  initial begin
    int cycles;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_signed = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", 128'(in_ready), 128'(0));
    check("reset.out_valid", 128'(out_valid), 128'(0));
    check("reset.busy", 128'(busy), 128'(0));
    check("reset.product", product, 128'(0));
    rst = 1'b0;
    #1;
    check("reset.in_ready_release", 128'(in_ready), 128'(1));
    $display("reset: released, in_ready=%0d", in_ready);

    // Unsigned vectors
    run_op("u_basic", 64'd3, 64'd5, 1'b0, 128'd15, 1'b0);
    run_op("u_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0);
    run_op("u_zero", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 128'd0, 1'b0);
    run_op("u_shift16", 64'h1234_5678_9ABC_DEF0, 64'h10, 1'b0,
           128'h0000_0000_0000_0001_2345_6789_ABCD_EF00, 1'b0);
    run_op("u_pow32", 64'h1_0000_0000, 64'h1_0000_0000, 1'b0,
           128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0);
    run_op("u_corner", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
           128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
    // out_ready already high: handshake on the first DONE cycle
    run_op("u_early", 64'h0123_4567_89AB_CDEF, 64'd1, 1'b0,
           128'h0000_0000_0000_0000_0123_4567_89AB_CDEF, 1'b1);

    // Signed-mode vectors (ignored mode bit gives the unsigned products)
`ifdef SEQ_MULT_SIGNED_EN
    run_op("s_neg3x5", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1, 1'b0);
    run_op("s_7xneg6", 64'd7, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6, 1'b0);
    run_op("s_neg1xneg1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
           128'd1, 1'b0);
`else
    run_op("s_neg3x5", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1,
           128'h0000_0000_0000_0004_FFFF_FFFF_FFFF_FFF1, 1'b0);
    run_op("s_7xneg6", 64'd7, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1,
           128'h0000_0000_0000_0006_FFFF_FFFF_FFFF_FFD6, 1'b0);
    run_op("s_neg1xneg1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0);
`endif
    run_op("s_corner", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
           128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
    run_op("s_7x6", 64'd7, 64'd6, 1'b1, 128'd42, 1'b0);

    // Back-pressure: hold out_ready low for 10 cycles with a competing request
    @(posedge clk); #1;
    op_a      = 64'd9;
    op_b      = 64'd11;
    op_signed = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("bp.latency", 128'(cycles), 128'(17));
    check("bp.product", product, 128'd99);
    for (int i = 0; i < 10; i++) begin
      op_a     = 64'd2;
      op_b     = 64'd2;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp.hold_product", product, 128'd99);
      check("bp.hold_valid", 128'(out_valid), 128'(1));
      check("bp.hold_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.release_valid", 128'(out_valid), 128'(0));
    check("bp.release_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    check("bp.not_queued", 128'(busy), 128'(0));
    $display("op bp: A=9 B=11 product=%h held 10 cycles", product);
    run_op("bp_next", 64'd5, 64'd5, 1'b0, 128'd25, 1'b0);

    // Reset in the middle of CALC
    @(posedge clk); #1;
    op_a      = 64'hFFFF_0000_FFFF_0000;
    op_b      = 64'h1234_5678_1234_5678;
    op_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("rst_mid.busy_before", 128'(busy), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid.out_valid", 128'(out_valid), 128'(0));
    check("rst_mid.busy", 128'(busy), 128'(0));
    check("rst_mid.product", product, 128'd0);
    check("rst_mid.in_ready_rst", 128'(in_ready), 128'(0));
    rst = 1'b0;
    #1;
    check("rst_mid.in_ready", 128'(in_ready), 128'(1));
    $display("reset: mid-CALC abort, product=%h", product);
    run_op("after_rst", 64'd7, 64'd6, 1'b0, 128'd42, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised, iterative shift-add multiplier. It is the sequential successor to the combinational `multiplier_64` and trades latency for area. It consumes `BITS_PER_CYCLE` multiplier bits per clock and supports unsigned and, when configured, signed two's-complement operands. Input and output use valid/ready handshakes, so the block drops into pipelined datapaths that need a wide product without a full array multiplier.

## Interface
- `WIDTH`, default 64: operand width. Must be ≥ 4. Product width is 2·`WIDTH`.
- `BITS_PER_CYCLE`, default 4: multiplier bits retired per iteration. Must be a power of two that divides `WIDTH`.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operands and mode are valid this cycle.
- `in_ready`, output, 1: block can accept operands. High only in IDLE.
- `A`, input, `WIDTH`: multiplicand.
- `B`, input, `WIDTH`: multiplier.
- `is_signed`, input, 1: treat A and B as two's complement. Sampled at accept.
- `out_valid`, output, 1: `product` is valid.
- `out_ready`, input, 1: consumer accepts `product`.
- `product`, output, 2·`WIDTH`: result register.
- `busy`, output, 1: high in CALC, FIX or DONE.

## Operation
- N = `WIDTH`/`BITS_PER_CYCLE` iterations. Four states: IDLE → CALC → FIX → DONE → IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, register |A|, |B| and the sign flag, clear the accumulator and iteration counter, then go to CALC.
  - In signed mode, the sign flag is A[MSB]^B[MSB] and |x| is the two's-complement negation of x when x[MSB]=1. In unsigned mode the operands pass through unchanged and the sign flag is 0.
- **CALC**
  - Each cycle, add (|A| × low `BITS_PER_CYCLE` bits of the B shift register) to the accumulator at the current bit offset.
  - Then shift the B register right by `BITS_PER_CYCLE` and increment the counter.
  - After the Nth iteration, go to FIX.
  - The accumulator is 2·`WIDTH` bits. Intermediate sums never exceed 2·`WIDTH` bits, so no carry is lost.
- **FIX**
  - `product` ← sign flag ? (~acc + 1) : acc, truncated to 2·`WIDTH` bits.
  - Assert `out_valid` and go to DONE.
- **DONE**
  - Hold `product` and `out_valid`=1 stable until `out_ready`=1.
  - On that handshake, drop `out_valid` and return to IDLE.
- Signed corner case: A = B = −2^(WIDTH−1) gives +2^(2·WIDTH−2). It must be exact, because |x| is held as an unsigned `WIDTH`-bit value.
- Zero operands take the full N iterations. There is no early termination.

## Timing
- **Reset values:** `in_ready`=0 while `rst`=1, then 1 in IDLE; `out_valid`=0; `busy`=0; `product`=0; state IDLE.
- **Latency:** the accept edge is t0. The FIX edge is t0+N+1, after which `out_valid`=1. Default latency is 17 cycles.
- **Throughput:** one operation per N+3 cycles minimum (accept, N CALC, FIX, output handshake). There is no overlap; `in_ready`=0 from the accept edge until IDLE is re-entered.
- `out_ready` held high before `out_valid` rises: the handshake completes on the first DONE cycle.
- `in_valid` while `in_ready`=0 is ignored. Operands are not queued.
- **Reset mid-operation:** `rst`=1 in any state on any edge aborts the operation. The outputs take their reset values on the next edge and the partial result is discarded.
- `out_valid` never falls without a completed handshake, except on reset.

## Configuration
- Macro `SEQ_MULT_SIGNED_EN`.
- Defined: `is_signed` is honoured as described above.
- Undefined: the `is_signed` port remains but is ignored. All operands are unsigned, the sign flag is tied to 0, and the negation logic is not synthesised.

## Test plan
- **Unsigned basic:** A=3, B=5, `is_signed`=0 → after 17 cycles, `product`=15 with `out_valid`=1.
- **Unsigned maximum:** A=B=64'hFFFF_FFFF_FFFF_FFFF → `product`=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- **Signed:** A=−3, B=5, `is_signed`=1 → `product`=128'hFFFF…FFF1 (−15).
- **Signed corner case:** A=B=64'h8000_0000_0000_0000 → `product`=128'h4000_0000_0000_0000_0000_0000_0000_0000.
  - Repeat with the macro undefined: the same operands give the unsigned result 2^126 and `is_signed` has no effect.
- **Back-pressure:** `out_ready`=0 for 10 cycles after `out_valid`.
  - Required: `product` stable, `in_ready`=0, and a second `in_valid` ignored.
  - Then `out_ready`=1 → IDLE on the next edge, and the next accept succeeds.
- **Reset mid-CALC:** `rst`=1 at iteration 8 → `out_valid`=0, `busy`=0, `product`=0, `in_ready`=1 after release.
  - A new operation A=7, B=6 then yields 42.
